fp32_mul_ctrl: RTL and testbench

- Single-precision (IEEE-754 binary32) multiply controller that wraps the team's 32x32 integer multiplier.
- Accepts two fp32 operands from the host and unpacks them. Special cases (NaN, Inf, zero) are resolved locally.
- For ordinary operands, the 24-bit significands are issued to the integer multiplier over its val/rdy request channel. The 64-bit product is consumed on the multiplier's response channel, then normalised and rounded, and a packed fp32 result is returned over a val/rdy output channel.

---
 rtl/fp32_mul_ctrl.sv | 151 +++++++++++++++
 tb/tb_fp32_mul_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_mul_ctrl.sv
// fp32_mul_ctrl: binary32 multiply controller around an external 32x32 integer multiplier (FTZ, round-nearest-even).
// Defining FP_MUL_FLAGS_EN adds out_flags = {invalid, overflow, underflow, inexact}.
module fp32_mul_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_val,
    output logic        in_rdy,
    output logic [31:0] out_msg,
    output logic        out_val,
    input  logic        out_rdy,
`ifdef FP_MUL_FLAGS_EN
    output logic [3:0]  out_flags,
`endif
    output logic [31:0] mul_req_msg_a,
    output logic [31:0] mul_req_msg_b,
    output logic        mul_req_val,
    input  logic        mul_req_rdy,
    input  logic [63:0] mul_resp_msg,
    input  logic        mul_resp_val,
    output logic        mul_resp_rdy
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NORM, DONE} state_t;
    state_t state_q, state_d;
    logic        sign_q, sign_d;
    logic [7:0]  ea_q, ea_d, eb_q, eb_d;
    logic [22:0] fa_q, fa_d, fb_q, fb_d;
    logic [47:0] prod_q, prod_d;
    logic [31:0] res_q, res_d;
`ifdef FP_MUL_FLAGS_EN
    logic [3:0]  flags_q, flags_d;
`endif
    logic [15:0] resp_unused;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign_in, special, invalid;
    logic [31:0] spec_res, norm_res;
    logic hi, guard, sticky, ovf, unf;
    logic [22:0] mant;
    logic [23:0] mant_r;
    logic signed [9:0] e_raw, e_fin;

    assign resp_unused = mul_resp_msg[63:48];
    // exp==0 covers denormals, which are flushed to signed zero
    assign a_nan   = (&in_a[30:23]) && (|in_a[22:0]);
    assign b_nan   = (&in_b[30:23]) && (|in_b[22:0]);
    assign a_inf   = (&in_a[30:23]) && !(|in_a[22:0]);
    assign b_inf   = (&in_b[30:23]) && !(|in_b[22:0]);
    assign a_zero  = in_a[30:23] == 8'h00;
    assign b_zero  = in_b[30:23] == 8'h00;
    assign sign_in = in_a[31] ^ in_b[31];
    assign special = a_nan || b_nan || a_inf || b_inf || a_zero || b_zero;
    assign invalid = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
    assign spec_res = invalid ? 32'h7FC00000 : (a_inf || b_inf) ? {sign_in, 8'hFF, 23'h0} : {sign_in, 31'h0};

    assign hi     = prod_q[47];
    assign mant   = hi ? prod_q[46:24] : prod_q[45:23];
    assign guard  = hi ? prod_q[23] : prod_q[22];
    assign sticky = hi ? |prod_q[22:0] : |prod_q[21:0];
    assign mant_r = {1'b0, mant} + 24'(guard && (sticky || mant[0]));
    assign e_raw  = 10'(ea_q) + 10'(eb_q) - (hi ? 10'd126 : 10'd127);
    assign e_fin  = e_raw + 10'(mant_r[23]);
    assign ovf    = e_fin >= 10'sd255;
    assign unf    = e_fin <= 10'sd0;
    // on mantissa carry-out mant_r[22:0] is already zero
    assign norm_res = ovf ? {sign_q, 8'hFF, 23'h0} : unf ? {sign_q, 31'h0} : {sign_q, e_fin[7:0], mant_r[22:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            ea_q    <= 8'h0;
            eb_q    <= 8'h0;
            fa_q    <= 23'h0;
            fb_q    <= 23'h0;
            prod_q  <= 48'h0;
            res_q   <= 32'h0;
`ifdef FP_MUL_FLAGS_EN
            flags_q <= 4'h0;
`endif
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            prod_q  <= prod_d;
            res_q   <= res_d;
`ifdef FP_MUL_FLAGS_EN
            flags_q <= flags_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_val) state_d = special ? DONE : ISSUE;
            ISSUE:   if (mul_req_rdy) state_d = mul_resp_val ? NORM : WAIT;
            WAIT:    if (mul_resp_val) state_d = NORM;
            NORM:    state_d = DONE;
            DONE:    if (out_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sign_d = sign_q;
        ea_d   = ea_q;
        eb_d   = eb_q;
        fa_d   = fa_q;
        fb_d   = fb_q;
        prod_d = prod_q;
        res_d  = res_q;
`ifdef FP_MUL_FLAGS_EN
        flags_d = flags_q;
`endif
        if (state_q == IDLE && in_val) begin
            sign_d = sign_in;
            ea_d   = in_a[30:23];
            eb_d   = in_b[30:23];
            fa_d   = in_a[22:0];
            fb_d   = in_b[22:0];
            res_d  = spec_res;
`ifdef FP_MUL_FLAGS_EN
            flags_d = {invalid, 3'b000};
`endif
        end
        if (((state_q == ISSUE && mul_req_rdy) || state_q == WAIT) && mul_resp_val)
            prod_d = mul_resp_msg[47:0];
        if (state_q == NORM) begin
            res_d = norm_res;
`ifdef FP_MUL_FLAGS_EN
            flags_d = {1'b0, ovf, unf, guard || sticky || ovf || unf};
`endif
        end
    end

    always_comb begin
        in_rdy        = state_q == IDLE;
        out_val       = state_q == DONE;
        mul_req_val   = state_q == ISSUE;
        mul_resp_rdy  = state_q == ISSUE || state_q == WAIT;
        mul_req_msg_a = (state_q == ISSUE) ? {8'h00, 1'b1, fa_q} : 32'h0;
        mul_req_msg_b = (state_q == ISSUE) ? {8'h00, 1'b1, fb_q} : 32'h0;
        out_msg       = res_q;
    end
`ifdef FP_MUL_FLAGS_EN
    assign out_flags = flags_q;
`endif
endmodule

// File: tb/tb_fp32_mul_ctrl.sv
// tb_fp32_mul_ctrl: scoreboard bench for fp32_mul_ctrl with a behavioural fp32 multiply model and a
// configurable-latency multiplier model; checks out_flags too when FP_MUL_FLAGS_EN is defined.
module tb_fp32_mul_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_a = 32'h0, in_b = 32'h0;
    logic        in_val = 1'b0;
    logic        in_rdy;
    logic [31:0] out_msg;
    logic        out_val, out_rdy;
    logic [31:0] mul_req_msg_a, mul_req_msg_b;
    logic        mul_req_val, mul_req_rdy;
    logic [63:0] mul_resp_msg;
    logic        mul_resp_val, mul_resp_rdy;
`ifdef FP_MUL_FLAGS_EN
    logic [3:0]  out_flags;
`endif
    logic        rand_mode = 1'b0, hold_force = 1'b0, ordy_force = 1'b1;
    logic        rnd_hold = 1'b0, rnd_ordy = 1'b1, mul_flush = 1'b0, mul_hold;
    int          lat_cfg = 0, lat_cnt = 0;
    logic        pend = 1'b0;
    logic [63:0] pend_p = 64'h0, prod;
    logic [35:0] exp_q[$];
    logic [35:0] exp_e;
    int          n_cmp = 0, n_err = 0;
    int          w;

    fp32_mul_ctrl dut (
        .clk(clk), .rst(rst),
        .in_a(in_a), .in_b(in_b), .in_val(in_val), .in_rdy(in_rdy),
        .out_msg(out_msg), .out_val(out_val), .out_rdy(out_rdy),
`ifdef FP_MUL_FLAGS_EN
        .out_flags(out_flags),
`endif
        .mul_req_msg_a(mul_req_msg_a), .mul_req_msg_b(mul_req_msg_b),
        .mul_req_val(mul_req_val), .mul_req_rdy(mul_req_rdy),
        .mul_resp_msg(mul_resp_msg), .mul_resp_val(mul_resp_val), .mul_resp_rdy(mul_resp_rdy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // multiplier model: lat_cfg==0 answers in the request cycle, otherwise lat_cfg cycles later
    always_comb begin
        prod         = {32'h0, mul_req_msg_a} * {32'h0, mul_req_msg_b};
        mul_hold     = rand_mode ? rnd_hold : hold_force;
        out_rdy      = rand_mode ? rnd_ordy : ordy_force;
        mul_req_rdy  = !mul_hold && !pend;
        mul_resp_val = (lat_cfg == 0) ? (mul_req_val && mul_req_rdy) : (pend && lat_cnt == 0);
        mul_resp_msg = {16'hA5C3, (lat_cfg == 0) ? prod[47:0] : pend_p[47:0]};
    end

    always @(posedge clk) begin
        rnd_hold <= $urandom_range(0, 3) == 0;
        rnd_ordy <= $urandom_range(0, 2) != 0;
        if (mul_flush) pend <= 1'b0;
        else if (pend) begin
            if (lat_cnt > 0) lat_cnt <= lat_cnt - 1;
            else if (mul_resp_rdy) pend <= 1'b0;
        end else if (lat_cfg > 0 && mul_req_val && mul_req_rdy) begin
            pend    <= 1'b1;
            lat_cnt <= lat_cfg - 1;
            pend_p  <= prod;
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // reference: {flags, result} from the arithmetic rules (exact integer product, RNE by remainder)
    function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic   s;
        int     ea, eb, e, sh;
        bit     an, bn, ai, bi, az, bz, inx;
        longint p, m, rem, half;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        an = ea == 255 && a[22:0] != 0;
        bn = eb == 255 && b[22:0] != 0;
        ai = ea == 255 && a[22:0] == 0;
        bi = eb == 255 && b[22:0] == 0;
        az = ea == 0;
        bz = eb == 0;
        if (an || bn || (ai && bz) || (bi && az)) return {4'b1000, 32'h7FC00000};
        if (ai || bi) return {4'b0000, s, 8'hFF, 23'h0};
        if (az || bz) return {4'b0000, s, 31'h0};
        p    = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
        sh   = (p >= (longint'(1) << 47)) ? 24 : 23;
        m    = p >> sh;
        rem  = p - (m << sh);
        half = longint'(1) << (sh - 1);
        inx  = rem != 0;
        if (rem > half || (rem == half && m[0])) m = m + 1;
        e = ea + eb - 127 + sh - 23;
        if (m == (longint'(1) << 24)) begin
            m = m >> 1;
            e = e + 1;
        end
        if (e >= 255) return {4'b0101, s, 8'hFF, 23'h0};
        if (e <= 0) return {4'b0011, s, 31'h0};
        return {3'b000, inx, s, e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] r;
        int k;
        r = $urandom();
        k = $urandom_range(0, 15);
        if (k == 0) r[30:23] = 8'h00;
        else if (k == 1) r[30:23] = 8'hFF;
        else if (k == 2) r[30:0] = {8'hFF, 23'h0};
        else if (k == 3) r[30:23] = 8'($urandom_range(1, 20));
        else if (k == 4) r[30:23] = 8'($urandom_range(230, 254));
        else if (k == 5) r[22:0] = 23'h7FFFFF - 23'($urandom_range(0, 3));
        else if (k == 6) r[22:0] = 23'h0;
        else r[30:23] = 8'($urandom_range(80, 175));
        return r;
    endfunction

    // monitor: pops one expectation per output transfer
    always @(negedge clk) begin
        if (!rst && out_val && out_rdy) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL out_unexpected got=%h exp=none", out_msg);
            end else begin
                exp_e = exp_q.pop_front();
                chk("out_msg", 64'(out_msg), 64'(exp_e[31:0]));
`ifdef FP_MUL_FLAGS_EN
                chk("out_flags", 64'(out_flags), 64'(exp_e[35:32]));
`endif
            end
        end
    end

    // called at posedge+1; returns there after the accepting edge
    task automatic send(input logic [31:0] a, input logic [31:0] b, input bit push, output int waits);
        in_a = a;
        in_b = b;
        in_val = 1'b1;
        waits = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!in_rdy && waits < 100);
        if (!in_rdy) chk("accept_timeout", 64'(in_rdy), 64'(1));
        else if (push) exp_q.push_back(ref_mul(a, b));
        @(posedge clk);
        #1;
        in_val = 1'b0;
    endtask

    task automatic lat_check(input string nm, input int exp_lat, input bit req_chk);
        int lat, reqs;
        lat = 0;
        reqs = 0;
        do begin
            @(negedge clk);
            lat++;
            if (mul_req_val) reqs++;
            if (req_chk && lat == 1) begin
                chk({nm, "_req_a"}, 64'(mul_req_msg_a), 64'h00C00000);
                chk({nm, "_req_b"}, 64'(mul_req_msg_b), 64'h00800000);
            end
        end while (!out_val && lat < 50);
        chk({nm, "_lat"}, 64'(lat), 64'(exp_lat));
        if (exp_lat == 1) chk({nm, "_noreq"}, 64'(reqs), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_rdy", 64'(in_rdy), 64'(1));
        chk("rst_out_val", 64'(out_val), 64'(0));
        chk("rst_req_val", 64'(mul_req_val), 64'(0));
        chk("rst_resp_rdy", 64'(mul_resp_rdy), 64'(0));
        chk("rst_out_msg", 64'(out_msg), 64'(0));
        chk("rst_req_msg", {mul_req_msg_a, mul_req_msg_b}, 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(32'h3FC00000, 32'h40000000, 1, w);
        lat_check("zw", 3, 1);
        send(32'h3F800001, 32'h3F800001, 1, w);
        lat_check("rne", 3, 0);
        send(32'h7F800000, 32'h00000000, 1, w);
        lat_check("inf0", 1, 0);
        send(32'h7F000000, 32'h40000000, 1, w);
        lat_check("ovf", 3, 0);
        send(32'h00800000, 32'h00800000, 1, w);
        lat_check("unf", 3, 0);
        hold_force = 1'b1;
        send(32'h3FC00000, 32'h40000000, 1, w);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_req_val", 64'(mul_req_val), 64'(1));
            chk("bp_req_a", 64'(mul_req_msg_a), 64'h00C00000);
            chk("bp_req_b", 64'(mul_req_msg_b), 64'h00800000);
        end
        @(posedge clk);
        #1;
        hold_force = 1'b0;
        ordy_force = 1'b0;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!out_val && w < 50);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_val", 64'(out_val), 64'(1));
            chk("bp_out_msg", 64'(out_msg), 64'h40400000);
            chk("bp_in_rdy", 64'(in_rdy), 64'(0));
        end
        @(posedge clk);
        #1;
        ordy_force = 1'b1;
        send(32'h40400000, 32'h40000000, 1, w);
        chk("b2b_accept_wait", 64'(w), 64'(2));
        lat_check("b2b", 3, 0);
        lat_cfg = 3;
        send(32'h3FC00000, 32'h40000000, 0, w);
        @(negedge clk);
        chk("wr_issue_req_val", 64'(mul_req_val), 64'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("wr_wait_req_val", 64'(mul_req_val), 64'(0));
        chk("wr_wait_resp_rdy", 64'(mul_resp_rdy), 64'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("wr_in_rdy", 64'(in_rdy), 64'(1));
        chk("wr_out_val", 64'(out_val), 64'(0));
        chk("wr_req_val", 64'(mul_req_val), 64'(0));
        chk("wr_resp_rdy", 64'(mul_resp_rdy), 64'(0));
        w = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_val || mul_resp_rdy) w++;
        end
        chk("wr_late_resp_ignored", 64'(w), 64'(0));
        @(posedge clk);
        #1;
        mul_flush = 1'b1;
        @(posedge clk);
        #1;
        mul_flush = 1'b0;
        lat_cfg = 2;
        send(32'h40400000, 32'hC0400000, 1, w);
        rand_mode = 1'b1;
        repeat (300) begin
            w = 0;
            while (!in_rdy && w < 100) begin
                @(posedge clk);
                #1;
                w++;
            end
            lat_cfg = $urandom_range(0, 3);
            send(rnd_fp(), rnd_fp(), 1, w);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
